// File: rtl/traffic_pkg.sv
// Shared definitions between the farm-road sensor conditioner and traffic_light:
// lamp encodings and the conditioner's state type.
package traffic_pkg;

   localparam logic [2:0] LIGHT_RED    = 3'b100;
   localparam logic [2:0] LIGHT_YELLOW = 3'b010;
   localparam logic [2:0] LIGHT_GREEN  = 3'b001;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_QUALIFY = 3'd1,
      S_REQUEST = 3'd2,
      S_SERVED  = 3'd3,
      S_FAULT   = 3'd4
   } sens_state_t;

endpackage

// File: rtl/farm_sensor_conditioner_sync2.sv
// Generic two-flop synchronizer for a single asynchronous level signal,
// cleared to 0 by the asynchronous active-low reset.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/farm_sensor_conditioner.sv
// Turns the raw farm-road loop detector into a latched, debounced vehicle call
// for traffic_light, with stuck-on loop detection and a served-call counter.
module farm_sensor_conditioner
   import traffic_pkg::*;
#(
   parameter int          DEBOUNCE     = 4,
   parameter int unsigned STUCK_CYCLES = 50000,
   parameter int          CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       loop_raw,
   input  logic [2:0] light_farm,
   output logic       sensor,
   output logic       fault,
   output logic [7:0] call_count
);

   localparam int QW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
   localparam logic [QW-1:0]    DEB     = QW'(DEBOUNCE);
   localparam logic [CNT_W-1:0] STUCK_C = CNT_W'(STUCK_CYCLES);

   sens_state_t      r_state, w_state_nxt;
   logic [QW-1:0]    r_qual, w_qual_nxt;
   logic [CNT_W-1:0] r_stuck, w_stuck_nxt;
   logic             w_loop_s;
   logic             w_stuck_hit;
   logic             w_call_inc;
   logic             w_green;
   logic             r_sensor, r_fault;
   logic [7:0]       r_call_count;

   sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (loop_raw),
      .o_q   (w_loop_s)
   );

   assign w_green = (light_farm == LIGHT_GREEN);

   // Stuck detector: saturating run length of consecutive synchronized highs.
   always_comb begin
      w_stuck_nxt = r_stuck;
      if (!w_loop_s)
         w_stuck_nxt = '0;
      else if (r_stuck != STUCK_C)
         w_stuck_nxt = r_stuck + CNT_W'(1);
      w_stuck_hit = w_loop_s && (w_stuck_nxt == STUCK_C);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_qual_nxt  = r_qual;
      w_call_inc  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_loop_s) begin
               if (DEBOUNCE <= 1) begin
                  w_state_nxt = S_REQUEST;
                  w_qual_nxt  = '0;
                  w_call_inc  = 1'b1;
               end else begin
                  w_state_nxt = S_QUALIFY;
                  w_qual_nxt  = QW'(1);
               end
            end
         end
         S_QUALIFY: begin
            if (!w_loop_s) begin
               w_state_nxt = S_IDLE;
               w_qual_nxt  = '0;
            end else if ((r_qual + QW'(1)) == DEB) begin
               w_state_nxt = S_REQUEST;
               w_qual_nxt  = '0;
               w_call_inc  = 1'b1;
            end else begin
               w_qual_nxt  = r_qual + QW'(1);
            end
         end
         S_REQUEST: begin
            if (w_green)
               w_state_nxt = S_SERVED;
         end
         S_SERVED: begin
            if (!w_green)
               w_state_nxt = S_IDLE;
         end
         S_FAULT: begin
            // Here the qualify counter counts consecutive lows toward recovery.
            if (w_loop_s) begin
               w_qual_nxt  = '0;
            end else if ((r_qual + QW'(1)) == DEB) begin
               w_state_nxt = S_IDLE;
               w_qual_nxt  = '0;
            end else begin
               w_qual_nxt  = r_qual + QW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_qual_nxt  = '0;
         end
      endcase

      if (w_stuck_hit) begin
         w_state_nxt = S_FAULT;
         w_qual_nxt  = '0;
         w_call_inc  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_qual       <= '0;
         r_stuck      <= '0;
         r_sensor     <= 1'b0;
         r_fault      <= 1'b0;
         r_call_count <= 8'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_qual       <= w_qual_nxt;
         r_stuck      <= w_stuck_nxt;
         r_sensor     <= (w_state_nxt == S_REQUEST) || (w_state_nxt == S_FAULT);
         r_fault      <= (w_state_nxt == S_FAULT);
         r_call_count <= r_call_count + {7'd0, w_call_inc};
      end
   end

   assign sensor     = r_sensor;
   assign fault      = r_fault;
   assign call_count = r_call_count;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// Self-checking bench for farm_sensor_conditioner: directed vector table,
// corner-case sequences and randomized traffic against a cycle reference model.
module tb_farm_sensor_conditioner;
   import traffic_pkg::*;

   localparam int DEB   = 4;
   localparam int STUCK = 64;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       loop_raw;
   logic [2:0] light_farm;
   logic       sensor;
   logic       fault;
   logic [7:0] call_count;

   int n_chk  = 0;
   int n_fail = 0;

   farm_sensor_conditioner #(
      .DEBOUNCE     (DEB),
      .STUCK_CYCLES (STUCK),
      .CNT_W        (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .loop_raw   (loop_raw),
      .light_farm (light_farm),
      .sensor     (sensor),
      .fault      (fault),
      .call_count (call_count)
   );

   always #5 clk = ~clk;

   // Reference model: run lengths of the delayed loop sample plus three flags.
   logic m_s1, m_s2;
   int   m_run_hi, m_qrun, m_lrun, m_calls;
   bit   m_call, m_served, m_fault;

   always @(posedge clk or negedge rst_n) begin
      logic s;
      bit   hit;
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0;
         m_run_hi = 0; m_qrun = 0; m_lrun = 0; m_calls = 0;
         m_call = 0; m_served = 0; m_fault = 0;
      end else begin
         s    = m_s2;
         m_s2 = m_s1;
         m_s1 = loop_raw;
         m_run_hi = s ? m_run_hi + 1 : 0;
         hit = s && (m_run_hi >= STUCK);
         if (hit) begin
            m_fault = 1; m_call = 0; m_served = 0; m_qrun = 0; m_lrun = 0;
         end else if (m_fault) begin
            m_lrun = s ? 0 : m_lrun + 1;
            if (m_lrun == DEB) begin
               m_fault = 0; m_lrun = 0; m_qrun = 0;
            end
         end else if (m_call) begin
            if (light_farm == LIGHT_GREEN) begin
               m_call = 0; m_served = 1;
            end
         end else if (m_served) begin
            if (light_farm != LIGHT_GREEN) m_served = 0;
         end else begin
            m_qrun = s ? m_qrun + 1 : 0;
            if (m_qrun == DEB) begin
               m_call = 1; m_qrun = 0; m_calls = (m_calls + 1) % 256;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic lr, input logic [2:0] lf);
      loop_raw   = lr;
      light_farm = lf;
      @(posedge clk);
      #1;
      chk("model_sensor", {31'd0, sensor}, {31'd0, m_call || m_fault});
      chk("model_fault",  {31'd0, fault},  {31'd0, m_fault});
      chk("model_count",  {24'd0, call_count}, 32'(m_calls));
   endtask

   typedef struct {
      string      nm;
      logic       lr;
      logic [2:0] lf;
      int         n;
      logic       es;
      logic       ef;
      int         ec;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic       r_lr;
      logic [2:0] r_lf;
      int         len;
      int         sel;

      rst_n = 1'b0; loop_raw = 1'b0; light_farm = LIGHT_RED;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_sensor", {31'd0, sensor}, 32'd0);
      chk("reset_fault",  {31'd0, fault},  32'd0);
      chk("reset_count",  {24'd0, call_count}, 32'd0);
      rst_n = 1'b1;

      tbl.push_back('{"idle_red",        1'b0, LIGHT_RED,   20, 1'b0, 1'b0, 0});
      tbl.push_back('{"glitch_high3",    1'b1, LIGHT_RED,    3, 1'b0, 1'b0, 0});
      tbl.push_back('{"glitch_low",      1'b0, LIGHT_RED,    6, 1'b0, 1'b0, 0});
      tbl.push_back('{"qual_edge4",      1'b1, LIGHT_RED,    5, 1'b0, 1'b0, 0});
      tbl.push_back('{"qual_edge5",      1'b1, LIGHT_RED,    1, 1'b1, 1'b0, 1});
      tbl.push_back('{"qual_hold",       1'b1, LIGHT_RED,    4, 1'b1, 1'b0, 1});
      tbl.push_back('{"call_latched",    1'b0, LIGHT_RED,    5, 1'b1, 1'b0, 1});
      tbl.push_back('{"served_drop",     1'b0, LIGHT_GREEN,  1, 1'b0, 1'b0, 1});
      tbl.push_back('{"back_idle",       1'b0, LIGHT_RED,    3, 1'b0, 1'b0, 1});
      tbl.push_back('{"call2",           1'b1, LIGHT_RED,    6, 1'b1, 1'b0, 2});
      tbl.push_back('{"veh_in_green",    1'b1, LIGHT_GREEN, 10, 1'b0, 1'b0, 2});
      tbl.push_back('{"green_end_wait",  1'b1, LIGHT_RED,    4, 1'b0, 1'b0, 2});
      tbl.push_back('{"green_end_req",   1'b1, LIGHT_RED,    1, 1'b1, 1'b0, 3});
      tbl.push_back('{"serve3",          1'b0, LIGHT_GREEN,  1, 1'b0, 1'b0, 3});
      tbl.push_back('{"idle3",           1'b0, LIGHT_RED,    4, 1'b0, 1'b0, 3});
      tbl.push_back('{"stuck_pre",       1'b1, LIGHT_RED,   65, 1'b1, 1'b0, 4});
      tbl.push_back('{"stuck_edge65",    1'b1, LIGHT_RED,    1, 1'b1, 1'b1, 4});
      tbl.push_back('{"fault_green",     1'b1, LIGHT_GREEN,  4, 1'b1, 1'b1, 4});
      tbl.push_back('{"fault_low4",      1'b0, LIGHT_GREEN,  5, 1'b1, 1'b1, 4});
      tbl.push_back('{"fault_exit",      1'b0, LIGHT_GREEN,  1, 1'b0, 1'b0, 4});
      tbl.push_back('{"after_fault",     1'b0, LIGHT_RED,    2, 1'b0, 1'b0, 4});

      foreach (tbl[i]) begin
         for (int c = 0; c < tbl[i].n; c++) cyc(tbl[i].lr, tbl[i].lf);
         chk({tbl[i].nm, "_sensor"}, {31'd0, sensor}, {31'd0, tbl[i].es});
         chk({tbl[i].nm, "_fault"},  {31'd0, fault},  {31'd0, tbl[i].ef});
         chk({tbl[i].nm, "_count"},  {24'd0, call_count}, 32'(tbl[i].ec));
      end

      // GREEN arrives on the same edge the stuck threshold is reached.
      for (int c = 0; c < 65; c++) cyc(1'b1, LIGHT_RED);
      chk("sg_pre_fault", {31'd0, fault}, 32'd0);
      chk("sg_pre_count", {24'd0, call_count}, 32'd5);
      cyc(1'b1, LIGHT_GREEN);
      chk("sg_fault",  {31'd0, fault},  32'd1);
      chk("sg_sensor", {31'd0, sensor}, 32'd1);
      for (int c = 0; c < 5; c++) cyc(1'b0, LIGHT_RED);
      chk("sg_still_fault", {31'd0, fault}, 32'd1);
      cyc(1'b0, LIGHT_RED);
      chk("sg_exit_fault", {31'd0, fault}, 32'd0);
      chk("sg_exit_count", {24'd0, call_count}, 32'd5);

      // Asynchronous reset while a call is latched.
      for (int c = 0; c < 6; c++) cyc(1'b1, LIGHT_RED);
      chk("ar_pre_sensor", {31'd0, sensor}, 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_sensor", {31'd0, sensor}, 32'd0);
      chk("ar_count",  {24'd0, call_count}, 32'd0);
      chk("ar_fault",  {31'd0, fault}, 32'd0);
      cyc(1'b0, LIGHT_RED);
      cyc(1'b0, LIGHT_RED);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) cyc(1'b0, LIGHT_RED);

      // 256 complete calls wrap the counter back to zero.
      for (int k = 0; k < 256; k++) begin
         for (int c = 0; c < 6; c++) cyc(1'b1, LIGHT_RED);
         cyc(1'b0, LIGHT_GREEN);
         for (int c = 0; c < 3; c++) cyc(1'b0, LIGHT_RED);
         if (k == 254) chk("wrap_255", {24'd0, call_count}, 32'd255);
      end
      chk("wrap_0", {24'd0, call_count}, 32'd0);

      // Randomized traffic checked cycle by cycle against the model.
      r_lf = LIGHT_RED;
      for (int k = 0; k < 400; k++) begin
         r_lr = 1'($urandom_range(0, 1));
         len  = ($urandom_range(0, 15) == 0) ? $urandom_range(60, 80) : $urandom_range(1, 8);
         for (int c = 0; c < len; c++) begin
            if ($urandom_range(0, 3) == 0) begin
               sel = $urandom_range(0, 7);
               if (sel < 3)       r_lf = LIGHT_RED;
               else if (sel == 3) r_lf = LIGHT_YELLOW;
               else if (sel < 7)  r_lf = LIGHT_GREEN;
               else               r_lf = 3'b011;
            end
            cyc(r_lr, r_lf);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
